// File: rtl/pea_ctrl_pkg.sv
// Shared definitions for the PE02 control word: field positions, opcodes,
// the idle control word and the sequencer state encoding.
package pea_ctrl_pkg;

  localparam int CTRL_W  = 11;

  localparam int DST_MSB = 10;
  localparam int DST_LSB = 8;
  localparam int OP1_MSB = 7;
  localparam int OP1_LSB = 5;
  localparam int OP2_MSB = 4;
  localparam int OP2_LSB = 2;
  localparam int OPC_MSB = 1;
  localparam int OPC_LSB = 0;

  typedef enum logic [1:0] {
    OPC_ADD = 2'b00,
    OPC_SUB = 2'b01,
    OPC_MUL = 2'b10,
    OPC_DIV = 2'b11
  } opcode_e;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [CTRL_W-1:0] make_ctrl(input logic [2:0] dst,
                                                  input logic [2:0] op1,
                                                  input logic [2:0] op2,
                                                  input opcode_e    opc);
    logic [CTRL_W-1:0] w;
    w = CTRL_NOP;
    w[DST_MSB:DST_LSB] = dst;
    w[OP1_MSB:OP1_LSB] = op1;
    w[OP2_MSB:OP2_LSB] = op2;
    w[OPC_MSB:OPC_LSB] = opc;
    return w;
  endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context memory: register file cleared to the idle word on reset, one
// synchronous write port and one combinational read port.
module pe_ctx_mem
  import pea_ctrl_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH),
  parameter int CTRL_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [CTRL_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [CTRL_WIDTH-1:0] rdata_o
);

  localparam logic [CTRL_WIDTH-1:0] NOP_WORD = CTRL_WIDTH'(CTRL_NOP);

  logic [CTRL_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// Issues a stored program of PE control words, each held for a dwell,
// repeated for a number of passes; all outputs come straight from registers.
module pe_ctrl_sequencer
  import pea_ctrl_pkg::*;
#(
  parameter int CTRL_WIDTH = 11,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH),
  parameter int DWELL_W    = 8,
  parameter int ITER_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [CTRL_WIDTH-1:0] cfg_wdata,
  input  logic                  start,
  input  logic [AW:0]           prog_len,
  input  logic [ITER_W-1:0]     iter_cnt,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  abort,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  ctrl_valid,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         pc,
  output state_e                dbg_state
);

  localparam logic [CTRL_WIDTH-1:0] NOP_WORD = CTRL_WIDTH'(CTRL_NOP);
  localparam logic [AW:0]           LEN_MAX  = (AW+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [AW:0]           len_q, len_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [DWELL_W-1:0]    rld_q, rld_d;
  logic [DWELL_W-1:0]    dcnt_q, dcnt_d;

  logic                  mem_we;
  logic [AW-1:0]         rd_addr;
  logic [CTRL_WIDTH-1:0] rd_data;
  logic                  last_word;
  logic [AW-1:0]         next_pc;
  logic [DWELL_W-1:0]    dwell_rld;

  pe_ctx_mem #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Memory is writable only while idle, so a running program cannot change.
  assign mem_we    = cfg_we && (state_q == IDLE);
  assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign next_pc   = last_word ? '0 : pc_q + AW'(1);
  assign rd_addr   = (state_q == RUN) ? next_pc : '0;
  // Counter holds D-1 so a dwell of 0 behaves like a dwell of 1.
  assign dwell_rld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctrl_q  <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      len_q   <= '0;
      iter_q  <= '0;
      rld_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      iter_q  <= iter_d;
      rld_q   <= rld_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    len_d   = len_q;
    iter_d  = iter_q;
    rld_d   = rld_q;
    dcnt_d  = dcnt_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
            iter_d  = iter_cnt;
            rld_d   = dwell_rld;
            dcnt_d  = dwell_rld;
            pc_d    = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            // Bypass a same-cycle write to word 0 so the first word is fresh.
            ctrl_d  = (cfg_we && (cfg_addr == '0)) ? cfg_wdata : rd_data;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          ctrl_d  = NOP_WORD;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          pc_d    = '0;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end else if (last_word && (iter_q == '0)) begin
          state_d = IDLE;
          ctrl_d  = NOP_WORD;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          pc_d    = '0;
          done_d  = 1'b1;
        end else begin
          pc_d   = next_pc;
          ctrl_d = rd_data;
          dcnt_d = rld_q;
          if (last_word) begin
            iter_d = (iter_q != '0) ? iter_q - ITER_W'(1) : '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed and randomized runs of the control sequencer checked cycle by
// cycle against a program/pass/dwell model of the issued word stream.
module tb_pe_ctrl_sequencer;
  import pea_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [10:0]   cfg_wdata;
  logic          start;
  logic [AW:0]   prog_len;
  logic [7:0]    iter_cnt;
  logic [7:0]    dwell;
  logic          abort;
  logic [10:0]   ctrl;
  logic          ctrl_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  state_e        dbg_state;

  logic [10:0]   mdl_mem [DEPTH];
  int            n_chk;
  int            n_fail;

  pe_ctrl_sequencer #(
    .CTRL_WIDTH (11),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .DWELL_W    (8),
    .ITER_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .prog_len   (prog_len),
    .iter_cnt   (iter_cnt),
    .dwell      (dwell),
    .abort      (abort),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctrl"},  32'(ctrl), 32'(CTRL_NOP));
    chk({tag, "_valid"}, 32'(ctrl_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask

  // Driver tasks
  task automatic cfg_write(input int addr, input logic [10:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
    mdl_mem[addr] = data;
  endtask

  // Called just after an edge E0; start is sampled at E1.
  task automatic run_check(input int len_raw, input int iters, input int dw,
                           input int abort_at, input bit mid_wr,
                           input bit co_wr, input logic [10:0] co_data);
    int eff_len, d, total, last_t, g;
    logic [10:0] exp_q[$];
    logic [10:0] e;
    eff_len = (len_raw > DEPTH) ? DEPTH : len_raw;
    d       = (dw == 0) ? 1 : dw;
    total   = eff_len * (iters + 1);
    last_t  = total * d + 1;
    if (co_wr) mdl_mem[0] = co_data;
    for (int k = 0; k < total; k++)
      for (int r = 0; r < d; r++)
        exp_q.push_back(mdl_mem[k % eff_len]);

    prog_len = (AW+1)'(len_raw);
    iter_cnt = 8'(iters);
    dwell    = 8'(dw);
    start    = 1'b1;
    if (co_wr) begin
      cfg_we    = 1'b1;
      cfg_addr  = '0;
      cfg_wdata = co_data;
    end
    for (int t = 1; t <= last_t + 1; t++) begin
      step();
      start  = 1'b0;
      cfg_we = 1'b0;
      abort  = 1'b0;
      if (abort_at != 0 && t == abort_at + 1) begin
        chk_idle("abort");
        chk("abort_pc", 32'(pc), 0);
        chk("abort_done", 32'(done), 0);
        step();
        chk("abort_done_after", 32'(done), 0);
        chk("abort_valid_after", 32'(ctrl_valid), 0);
        return;
      end
      if (t < last_t) begin
        e = exp_q.pop_front();
        g = (t - 1) / d;
        chk("word_ctrl",  32'(ctrl), 32'(e));
        chk("word_valid", 32'(ctrl_valid), 1);
        chk("word_busy",  32'(busy), 1);
        chk("word_done",  32'(done), 0);
        chk("word_pc",    32'(pc), 32'(g % eff_len));
      end else if (t == last_t) begin
        chk("done_pulse", 32'(done), 1);
        chk_idle("done");
      end else begin
        chk("done_single", 32'(done), 0);
        chk_idle("post");
      end
      if (t == abort_at) abort = 1'b1;
      if (mid_wr && t == 2) begin
        cfg_we    = 1'b1;
        cfg_addr  = AW'(1);
        cfg_wdata = 11'h7ff;
        start     = 1'b1;
      end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    prog_len  = '0;
    iter_cnt  = '0;
    dwell     = '0;
    abort     = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = CTRL_NOP;
    step();
    step();
    chk_idle("reset");
    chk("reset_done", 32'(done), 0);
    chk("reset_pc", 32'(pc), 0);
    rst_n = 1'b1;
    step();
    chk_idle("reset_rel");

    // Basic run
    cfg_write(0, 11'b011_000_001_00);
    cfg_write(1, make_ctrl(3'b110, 3'b001, 3'b010, OPC_MUL));
    cfg_write(2, make_ctrl(3'b100, 3'b011, 3'b011, OPC_DIV));
    chk("idle_no_output", 32'(ctrl_valid), 0);
    run_check(3, 0, 5, 0, 1'b0, 1'b0, '0);

    // Repeat with dwell zero
    run_check(3, 2, 0, 0, 1'b0, 1'b0, '0);

    // Abort mid-run at E7
    run_check(3, 0, 5, 7, 1'b0, 1'b0, '0);

    // Write and second start during a run are ignored; next run shows old word
    run_check(3, 0, 2, 0, 1'b1, 1'b0, '0);
    run_check(3, 0, 1, 0, 1'b0, 1'b0, '0);

    // Boundary lengths
    run_check(0, 0, 3, 0, 1'b0, 1'b0, '0);
    for (int i = 3; i < DEPTH; i++) cfg_write(i, 11'($urandom));
    run_check(DEPTH + 1, 0, 1, 0, 1'b0, 1'b0, '0);

    // Abort and start together in idle: start dropped
    prog_len = 5'd3;
    start    = 1'b1;
    abort    = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("abort_start");
    chk("abort_start_done", 32'(done), 0);
    step();
    chk("abort_start_busy2", 32'(busy), 0);

    // Write to word 0 in the start cycle is seen on the first word
    run_check(2, 1, 2, 0, 1'b0, 1'b1, 11'h5a5);

    // Randomized programs
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DEPTH; i++) cfg_write(i, 11'($urandom));
      run_check($urandom_range(1, DEPTH + 2), $urandom_range(0, 2),
                $urandom_range(0, 3), 0, 1'b0, 1'b0, '0);
    end

    // Asynchronous reset during word 1
    prog_len = 5'd3;
    iter_cnt = 8'd0;
    dwell    = 8'd5;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 6; t++) step();
    chk("pre_reset_pc", 32'(pc), 1);
    chk("pre_reset_ctrl", 32'(ctrl), 32'(mdl_mem[1]));
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_done", 32'(done), 0);
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = CTRL_NOP;
    step();
    rst_n = 1'b1;
    step();
    run_check(3, 0, 1, 0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
